// File: rtl/fb_pkg.sv
// Shared constants, clear-FSM encoding and address helper for the low-res framebuffer.
// The framebuffer holds 200x150 stored pixels, and each one is shown 4x4 on an 800x600 display.
package fb_pkg;

  localparam int FB_W        = 200;
  localparam int FB_H        = 150;
  localparam int SCALE_SHIFT = 2;
  localparam int COLOR_W     = 12;
  localparam int ADDR_W      = 15;
  localparam int FB_WORDS    = FB_W * FB_H;

  localparam int DISP_W = 800;
  localparam int DISP_H = 600;
  localparam logic [9:0] PIX_BLANK = 10'h3FF;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WORDS - 1);

  // Bit positions of each colour field inside a stored word.
  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Computes y*200 + x using shifts and adds (200 = 128 + 64 + 8).
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] y, input logic [7:0] x);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 6) + (yw << 3) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port block RAM with one write port and one synchronous read-first read port.
// A read from an address that is written on the same edge returns the old word.
module fb_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 30000
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: a 2-stage pixel read pipeline, a ready/valid pixel write port,
// and a full-image clear engine that shares the RAM write port with the pixel write port.
module fb_scanout
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  output logic [3:0]         out_r,
  output logic [3:0]         out_g,
  output logic [3:0]         out_b,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [7:0]         wr_x,
  input  logic [7:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               clr_start,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic               clr_done
);

  clr_state_e         state_q;
  logic [ADDR_W-1:0]  clr_cnt_q;
  logic [COLOR_W-1:0] clr_color_q;
  logic               clr_busy_q;
  logic               clr_done_q;

  logic [ADDR_W-1:0]  rd_addr_d, rd_addr_q;
  logic               vld_a_d, vld_a_q;
  logic               vld_b_q;
  logic [COLOR_W-1:0] rd_data;

  logic               wr_fire;
  logic               wr_in_range;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [COLOR_W-1:0] ram_wdata;

  // Stage A: map display coordinates onto a stored-pixel address.
  always_comb begin
    rd_addr_d = fb_addr(pixel_y[SCALE_SHIFT +: 8], pixel_x[SCALE_SHIFT +: 8]);
    vld_a_d   = (pixel_x != PIX_BLANK) && (pixel_y != PIX_BLANK) &&
                (pixel_x < 10'(DISP_W)) && (pixel_y < 10'(DISP_H));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      vld_a_q   <= 1'b0;
      vld_b_q   <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      vld_a_q   <= vld_a_d;
      vld_b_q   <= vld_a_q;
    end
  end

  // The write port stays closed for the whole clear and also in the cycle where a clear is requested.
  assign wr_ready    = (state_q == ST_IDLE) && !clr_start;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 8'(FB_H));

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = fb_addr(wr_y, wr_x);
    ram_wdata = wr_color;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = clr_color_q;
    end else if (wr_fire && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  // clr_done is raised one cycle early so that the registered pulse lines up with the last write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_start) begin
            state_q     <= ST_CLEAR;
            clr_color_q <= clr_color;
            clr_cnt_q   <= '0;
            clr_busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
          end else begin
            clr_cnt_q  <= clr_cnt_q + 1'b1;
            clr_done_q <= (clr_cnt_q == CLR_LAST - 1'b1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

  fb_ram #(
    .DATA_W (COLOR_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FB_WORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_data)
  );

  // Stage B: the colour comes straight from the RAM output register and is blanked when invalid.
  assign out_r = vld_b_q ? rd_data[R_HI:R_LO] : 4'h0;
  assign out_g = vld_b_q ? rd_data[G_HI:G_LO] : 4'h0;
  assign out_b = vld_b_q ? rd_data[B_HI:B_LO] : 4'h0;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: scan latency, blanking, pixel writes, clear engine and reset abort.
module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  pixel_x, pixel_y;
  logic [3:0]  out_r, out_g, out_b;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x, wr_y;
  logic [11:0] wr_color;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        clr_busy, clr_done;

  wire [11:0] out_rgb = {out_r, out_g, out_b};

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0]  qx[$];
  logic [9:0]  qy[$];
  logic [11:0] qe[$];

  always #5 clk = ~clk;

  fb_scanout dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_color  (wr_color),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_pt(input int x, input int y, input logic [11:0] e);
    qx.push_back(10'(x));
    qy.push_back(10'(y));
    qe.push_back(e);
  endtask

  // Streams the queued coordinates back to back and expects each colour exactly two cycles later.
  task automatic scan_run(input string tag);
    int n;
    n = qx.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        pixel_x = qx[i];
        pixel_y = qy[i];
      end else begin
        pixel_x = 10'h3FF;
        pixel_y = 10'h3FF;
      end
      if (i >= 2) begin
        chk($sformatf("%s[%0d] (%0d,%0d)", tag, i - 2, qx[i-2], qy[i-2]), out_rgb, qe[i-2]);
      end
      step();
    end
    $display("scan %s: %0d pixels", tag, n);
    qx.delete();
    qy.delete();
    qe.delete();
  endtask

  task automatic do_write(input string tag, input int x, input int y, input logic [11:0] c);
    wr_valid = 1'b1;
    wr_x     = 8'(x);
    wr_y     = 8'(y);
    wr_color = c;
    chk({tag, "_ready"}, wr_ready, 1);
    step();
    wr_valid = 1'b0;
    $display("write %s: (%0d,%0d) = 0x%03h", tag, x, y, c);
  endtask

  // Full clear with a write held pending and a stray clr_start partway through.
  task automatic run_clear(input string tag, input logic [11:0] color);
    int busy_cnt, done_cnt, done_idx, rdy_hi;
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = 0;
    rdy_hi   = 0;
    clr_start = 1'b1;
    clr_color = color;
    wr_valid  = 1'b1;
    wr_x      = 8'd20;
    wr_y      = 8'd20;
    wr_color  = 12'hFFF;
    #1;
    chk({tag, "_ready_at_start"}, wr_ready, 0);
    step();
    clr_start = 1'b0;
    clr_color = 12'hFFF;
    for (int c = 0; c < 31000; c++) begin
      if (!clr_busy) break;
      busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_idx = busy_cnt;
      end
      if (wr_ready) rdy_hi++;
      clr_start = (busy_cnt == 500);
      step();
    end
    wr_valid  = 1'b0;
    clr_start = 1'b0;
    chk({tag, "_busy_cycles"}, busy_cnt, 30000);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_on_last"}, done_idx, 30000);
    chk({tag, "_ready_during"}, rdy_hi, 0);
    chk({tag, "_done_after"}, clr_done, 0);
    chk({tag, "_ready_after"}, wr_ready, 1);
    $display("clear %s: colour 0x%03h, %0d busy cycles", tag, color, busy_cnt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    reset_n   = 1'b0;
    pixel_x   = 10'h3FF;
    pixel_y   = 10'h3FF;
    wr_valid  = 1'b0;
    wr_x      = '0;
    wr_y      = '0;
    wr_color  = '0;
    clr_start = 1'b0;
    clr_color = '0;

    repeat (3) step();
    chk("rst_rgb", out_rgb, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    reset_n = 1'b1;
    step();
    chk("rst_ready", wr_ready, 1);
    $display("reset released");

    run_clear("clr_a5", 12'h0A5);

    add_pt(0, 0, 12'h0A5);
    add_pt(799, 599, 12'h0A5);
    add_pt(400, 300, 12'h0A5);
    add_pt(3, 3, 12'h0A5);
    add_pt(796, 0, 12'h0A5);
    add_pt(0, 599, 12'h0A5);
    add_pt(80, 80, 12'h0A5);
    scan_run("after_clr");

    do_write("w00", 0, 0, 12'hF00);
    for (int x = 0; x < 5; x++) add_pt(x, 0, (x < 4) ? 12'hF00 : 12'h0A5);
    scan_run("row0");

    add_pt(1023, 1023, 12'h000);
    add_pt(810, 0, 12'h000);
    add_pt(0, 1023, 12'h000);
    add_pt(800, 0, 12'h000);
    add_pt(0, 600, 12'h000);
    add_pt(3, 0, 12'hF00);
    scan_run("blank");

    do_write("drop_x200", 200, 0, 12'h0F0);
    do_write("drop_y150", 0, 150, 12'h0F0);
    add_pt(0, 0, 12'hF00);
    add_pt(0, 4, 12'h0A5);
    add_pt(799, 599, 12'h0A5);
    scan_run("dropped");

    // Collision: the read and the write of stored (10,10) land on the same edge.
    pixel_x = 10'd40;
    pixel_y = 10'd40;
    step();
    wr_valid = 1'b1;
    wr_x     = 8'd10;
    wr_y     = 8'd10;
    wr_color = 12'h123;
    chk("coll_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    chk("coll_old", out_rgb, 12'h0A5);
    step();
    chk("coll_new", out_rgb, 12'h123);
    $display("collision write (10,10) = 0x123");

    // Reset arriving mid-clear aborts it.
    done_seen = 0;
    clr_start = 1'b1;
    clr_color = 12'hFFF;
    step();
    clr_start = 1'b0;
    for (int c = 1; c < 100; c++) begin
      if (clr_done) done_seen++;
      step();
    end
    chk("abort_busy_before", clr_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", clr_busy, 0);
    chk("abort_done", clr_done, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    if (clr_done) done_seen++;
    chk("abort_done_seen", done_seen, 0);
    chk("abort_ready", wr_ready, 1);
    $display("clear aborted by reset");

    add_pt(0, 0, 12'hFFF);
    add_pt(392, 0, 12'hFFF);
    add_pt(400, 0, 12'h0A5);
    add_pt(40, 40, 12'h123);
    add_pt(799, 599, 12'h0A5);
    scan_run("partial");

    run_clear("clr_3c7", 12'h3C7);
    add_pt(0, 0, 12'h3C7);
    add_pt(40, 40, 12'h3C7);
    add_pt(80, 80, 12'h3C7);
    add_pt(799, 599, 12'h3C7);
    scan_run("after_clr2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
